// File: rtl/fifo_burst_reader_pkg.sv
// Shared constants and types for the FIFO burst reader.
// State encodings and prefetch buffer depth.
package fifo_burst_reader_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_DRAIN = ST_DRAIN
  } state_t;

endpackage

// File: rtl/fifo_burst_reader_skid.sv
// Two-entry register buffer holding {last, data} words.
// Ports: clk, rst, push/push_data, pop, head, count.
module fifo_skid_buf
  import fifo_burst_reader_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [BUF_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && (cnt != 2'd2);
  assign do_pop  = pop && (cnt != 2'd0);
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops N words from a standard-mode FIFO and streams them
// out on valid/ready with a last flag on the final word.
// Ports: i_Clk/i_Rst, i_Start/i_Len command, o_Busy/o_Done,
// FIFO read side (o_Rd_En, i_Rd_DV, i_Rd_Data, i_Empty),
// stream side (o_Valid, i_Ready, o_Data, o_Last).
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Start,
  input  logic [LEN_W-1:0] i_Len,
  output logic             o_Busy,
  output logic             o_Done,
  output logic             o_Rd_En,
  input  logic             i_Rd_DV,
  input  logic [WIDTH-1:0] i_Rd_Data,
  input  logic             i_Empty,
  output logic             o_Valid,
  input  logic             i_Ready,
  output logic [WIDTH-1:0] o_Data,
  output logic             o_Last
);

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] rem_issue;
  logic [LEN_W-1:0] rem_deliver;
  logic             inflight;
  logic             inflight_last;
  logic             done;
  logic             rst_q;
  logic             rd_en;
  logic             pop;
  logic             push;
  logic [1:0]       buf_cnt;
  logic [WIDTH:0]   head;
  logic [2:0]       occ;

  assign pop  = o_Valid && i_Ready;
  assign push = i_Rd_DV && inflight && (buf_cnt != 2'd2);

  // Buffer slots committed after this edge: held words
  // plus the read in flight, minus the word leaving now.
  assign occ = {1'b0, buf_cnt} + {2'b0, inflight}
             - {2'b0, pop};

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_Start && (i_Len != '0)) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        rd_en = !i_Empty && (occ < 3'd2);
        if (rd_en && (rem_issue == LEN_W'(1))) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && (rem_deliver == LEN_W'(1))) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rem_issue     <= '0;
      rem_deliver   <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      inflight      <= rd_en;
      // The final read carries the last flag into the buffer.
      inflight_last <= rd_en && (rem_issue == LEN_W'(1));
      done <= ((state == S_IDLE) && i_Start && (i_Len == '0))
           || ((state == S_DRAIN) && pop
               && (rem_deliver == LEN_W'(1)));
      if ((state == S_IDLE) && i_Start) begin
        rem_issue   <= i_Len;
        rem_deliver <= i_Len;
      end else begin
        if (rd_en) rem_issue <= rem_issue - LEN_W'(1);
        if (pop && (state != S_IDLE)) begin
          rem_deliver <= rem_deliver - LEN_W'(1);
        end
      end
    end
  end

  // A read issued just before reset still returns data in
  // the following cycle; that word is expected and dropped.
  always_ff @(posedge i_Clk) begin
    rst_q <= i_Rst;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst && !rst_q && i_Rd_DV) begin
      assert (inflight && (buf_cnt != 2'd2));
    end
  end

  fifo_skid_buf #(
    .W(WIDTH + 1)
  ) u_buf (
    .clk       (i_Clk),
    .rst       (i_Rst),
    .push      (push),
    .push_data ({inflight_last, i_Rd_Data}),
    .pop       (pop),
    .head      (head),
    .count     (buf_cnt)
  );

  assign o_Valid = (buf_cnt != 2'd0);
  assign o_Data  = head[WIDTH-1:0];
  assign o_Last  = o_Valid && head[WIDTH];
  assign o_Busy  = (state != S_IDLE);
  assign o_Done  = done;
  assign o_Rd_En = rd_en;

endmodule
